// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers for the MIPS150 EX stage.
// Optional macro MUL_DIV_FAST_MUL_EN: MULT/MULTU take a single-cycle combinational path.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;

  logic               w_signed;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH+1:0]   w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mulRes;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remv;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;

  // Even opcodes (MULT, DIV) are the signed ones; the core works on magnitudes.
  assign w_signed = ~op[0];
  assign w_absA   = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_absB   = (w_signed && b[WIDTH-1]) ? -b : b;

  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opA} : '0);
  assign w_mulNext = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: dividend bits shift out of the low half of r_acc as quotient bits shift in.
  assign w_trial = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_trial - {2'b00, r_opB};
  assign w_qBit  = ~w_diff[WIDTH+1];

`ifdef MUL_DIV_FAST_MUL_EN
  assign w_prod = (2*WIDTH)'(r_opA) * (2*WIDTH)'(r_opB);
`else
  assign w_prod = r_acc;
`endif

  assign w_mulRes = r_negQ ? -w_prod : w_prod;
  assign w_quo    = r_acc[WIDTH-1:0];
  assign w_remv   = r_rem[WIDTH-1:0];
  assign w_resLo  = r_isDiv ? (r_negQ ? -w_quo : w_quo) : w_mulRes[WIDTH-1:0];
  assign w_resHi  = r_isDiv ? (r_negR ? -w_remv : w_remv) : w_mulRes[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_opA   <= w_absA;
                r_opB   <= w_absB;
                r_isDiv <= op[1];
                r_negQ  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_negR  <= w_signed & a[WIDTH-1];
                r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_absA : w_absB)};
                r_rem   <= '0;
                r_cnt   <= CNT_W'(WIDTH);
`ifdef MUL_DIV_FAST_MUL_EN
                r_state <= op[1] ? S_RUN : S_FIN;
`else
                r_state <= S_RUN;
`endif
              end
              3'd4: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              3'd5: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_isDiv) begin
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_qBit};
            r_rem            <= w_qBit ? w_diff[WIDTH:0] : w_trial[WIDTH:0];
          end else begin
            r_acc <= w_mulNext;
          end
          if (r_cnt == CNT_W'(1)) r_state <= S_FIN;
        end
        S_FIN: begin
          r_hi    <= w_resHi;
          r_lo    <= w_resLo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random scoreboard bench for mul_div_unit; expected results and done cycles
// are queued at start time and compared on the cycle the result is due.
module tb_mul_div_unit;

  localparam int W        = 32;
  localparam int ITER_LAT = W + 2;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = ITER_LAT;
`endif

  typedef struct {
    logic [2*W-1:0] res;
    int             doneCyc;
  } exp_t;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           start = 1'b0;
  logic [2:0]     op    = 3'd0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  int             cyc    = 0;
  int             checks = 0;
  int             errors = 0;
  exp_t           sb[$];
  logic [W-1:0]   mHi = '0;
  logic [W-1:0]   mLo = '0;
  logic           monExp;
  exp_t           monE;
  int             c0;
  logic [2:0]     ro;
  logic [W-1:0]   rx;
  logic [W-1:0]   ry;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [2*W-1:0] observed,
                             input logic [2*W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic int latencyOf(input logic [2:0] o);
    if (o <= 3'd1) return MUL_LAT;
    if (o <= 3'd3) return ITER_LAT;
    return 1;
  endfunction

  // Independent reference built on the simulator's native arithmetic.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sA, sB, q, r;
    sA = longint'($signed(x));
    sB = longint'($signed(y));
    case (o)
      3'd0: return 64'(sA * sB);
      3'd1: return 64'(x) * 64'(y);
      3'd2: begin
        if (y == 0) return {x, (x[W-1] ? 32'd1 : 32'hFFFF_FFFF)};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        q = sA / sB;
        r = sA % sB;
        return {r[W-1:0], q[W-1:0]};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {mHi, mLo};
    endcase
  endfunction

  // Expected-done check runs every cycle so early, late and spurious pulses all show up.
  always @(negedge clk) begin
    if (!rst) begin
      monExp = (sb.size() != 0) && (sb[0].doneCyc == cyc);
      checkOutput("done", 64'(done), 64'(monExp));
      if (monExp) begin
        monE = sb.pop_front();
        checkOutput("result", {hi, lo}, monE.res);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic gotoCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveStart(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [2*W-1:0] res);
    exp_t e;
    e.res     = res;
    e.doneCyc = cyc + latencyOf(o);
    sb.push_back(e);
    {mHi, mLo} = res;
    driveStart(o, x, y);
  endtask

  task automatic applyMt(input logic [2:0] o, input logic [W-1:0] x);
    applyStimulus(o, x, '0, (o == 3'd4) ? {x, mLo} : {mHi, x});
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 3 * W + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    waitIdle();
    applyStimulus(3'd0, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    waitIdle();

    c0 = cyc;
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    @(negedge clk);
    checkOutput("busy_first", 64'(busy), 64'd1);
    gotoCycle(c0 + W + 1);
    @(negedge clk);
    checkOutput("busy_last", 64'(busy), 64'd1);
    waitIdle();
    applyStimulus(3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    waitIdle();

    applyStimulus(3'd3, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF});
    waitIdle();
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    waitIdle();
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'd1});
    waitIdle();
    applyStimulus(3'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    waitIdle();
    applyMt(3'd4, 32'hDEAD_BEEF);
    waitIdle();

    // Reset while busy: the in-flight result must never appear.
    c0 = cyc;
`ifdef MUL_DIV_FAST_MUL_EN
    applyStimulus(3'd1, 32'd5, 32'd6, 64'd30);
`else
    driveStart(3'd1, 32'd5, 32'd6);
`endif
    gotoCycle(c0 + 10);
    driveStart(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    checkOutput("busy_during_ignored_start", 64'(busy), 64'd1);
    gotoCycle(c0 + 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mHi = '0;
    mLo = '0;
    @(negedge clk);
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;
    repeat (W + 6) begin
      @(posedge clk);
      #1;
    end
    applyMt(3'd5, 32'h0000_ABCD);
    waitIdle();

    // Back-to-back: second start lands in the first op's done cycle.
    c0 = cyc;
    applyStimulus(3'd3, 32'd9, 32'd4, {32'd1, 32'd2});
    gotoCycle(c0 + ITER_LAT);
    applyStimulus(3'd1, 32'd3, 32'd3, {32'd0, 32'd9});
    waitIdle();

    driveStart(3'd6, 32'h1234_5678, 32'd5);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("ignored_op_hilo", {hi, lo}, {mHi, mLo});
    checkOutput("ignored_op_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i == 3) ry = '0;
      if (i == 5) ry = 32'hFFFF_FFFF;
      if (i == 7) ry = 32'($urandom_range(1, 255));
      applyStimulus(ro, rx, ry, model(ro, rx, ry));
      waitIdle();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, iterative multiply/divide unit for the MIPS150 EX stage, alongside the combinational ALU.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into private HI/LO registers.
- Exposes a start/busy/done handshake so the pipeline can stall on MFHI/MFLO while an operation is in flight.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Legal range 4..64.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. 6 and 7 are ignored: no state change, no done.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in that same cycle.
- hi  out  WIDTH  HI register (high product half / remainder).
- lo  out  WIDTH  LO register (low product half / quotient).

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Overrides any in-flight operation and any start in the same cycle. The partial result is discarded.
- States: IDLE, RUN, FIN.
- IDLE, start=1, op in 0..3:
  - latch |a|, |b| for signed ops (else raw a, b) and the result sign flags;
  - load counter=WIDTH and go to RUN; busy goes high the next cycle.
- IDLE, start=1, op 4 (MTHI) or 5 (MTLO): write a into hi or lo at that edge. done=1 the following cycle; busy stays 0.
- RUN: one iteration per cycle, counter decrements.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; the remainder register is WIDTH+1 bits.
  - At counter==1, go to FIN.
- FIN (one cycle), at the next edge:
  - apply sign correction (two's complement negate);
  - write {hi,lo};
  - done=1 and busy=0 in the following cycle;
  - return to IDLE.
- Latency: start in cycle 0 gives busy=1 in cycles 1..WIDTH+1 and done=1 with a valid hi/lo in cycle WIDTH+2. Latency is fixed and independent of operand values.
- Signed multiply: product sign = a[MSB]^b[MSB]. The full 2*WIDTH product is exact.
- Signed divide:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend;
  - negative quotient is negated only when the sign flags differ.
- Divide by zero (b==0), full latency still applies:
  - DIVU: lo={WIDTH{1}}, hi=a.
  - DIV: hi=a, lo = -1 if a>=0, else +1.
- Signed overflow (DIV of most-negative by -1): lo=most-negative, hi=0. No trap is raised.
- start while busy=1: ignored; the in-flight operation is unaffected.
- start in the same cycle as done: accepted, since busy=0 in that cycle.
- hi/lo hold their values in every cycle except the result or MT write edge.
- Operands a and b may change after the start cycle without effect.

Optional Feature:
- Macro: MUL_DIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU bypass RUN and compute the product combinationally from the latched operands.
  - Path is IDLE -> FIN -> IDLE: busy=1 for cycle 1 only, done=1 in cycle 2.
  - DIV/DIVU are unchanged.
- Undefined: all four operations use the iterative path with the latency above.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MUL_DIV_FAST_MUL_EN, the same result appears with done in cycle 2.
3. DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2.
4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Start MULTU 5*6, pulse start with DIVU in cycle 10 (ignored), then assert rst in cycle 20 -> busy=0, hi=lo=0 from cycle 21, no done pulse. Next MTLO a=0xABCD -> lo=0xABCD, done one cycle later.
6. Back-to-back: DIVU 9/4 with a new MULTU 3*3 held on start during the done cycle -> first done shows hi=1, lo=2; second done, WIDTH+2 cycles later, shows hi=0, lo=9.
